// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: table geometry, 2-bit counter
// states, counter update operations and PC index/tag extraction helpers.
package branch_predictor_pkg;

  localparam int INDEX_BITS = 4;
  localparam int ENTRIES    = 1 << INDEX_BITS;
  localparam int TAG_BITS   = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_e;

  typedef enum logic [1:0] {
    CTR_HOLD = 2'b00,
    CTR_INC  = 2'b01,
    CTR_DEC  = 2'b10,
    CTR_INIT = 2'b11
  } ctr_op_e;

  typedef logic [INDEX_BITS-1:0] bp_idx_t;
  typedef logic [TAG_BITS-1:0]   bp_tag_t;

  function automatic bp_idx_t bp_index(input logic [31:0] pc);
    return pc[INDEX_BITS+1:2];
  endfunction

  function automatic bp_tag_t bp_tag(input logic [31:0] pc);
    return pc[31:INDEX_BITS+2];
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-value for one 2-bit saturating direction counter.
// Saturates at both ends; INIT loads weak-taken for a fresh allocation.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_ctr_e ctr_i,
  input  ctr_op_e op_i,
  output bp_ctr_e ctr_o
);

  logic [1:0] raw;

  always_comb begin
    raw   = ctr_i;
    ctr_o = ctr_i;
    case (op_i)
      CTR_INC:  if (ctr_i != BP_ST)  ctr_o = bp_ctr_e'(raw + 2'd1);
      CTR_DEC:  if (ctr_i != BP_SNT) ctr_o = bp_ctr_e'(raw - 2'd1);
      CTR_INIT: ctr_o = BP_WT;
      default:  ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-cycle lookup for the fetch PC,
// EX-stage training, mispredict flush/redirect and event counters.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] IF_PC,
  output logic        PRED_TAKEN,
  output logic [31:0] PRED_TARGET,
  input  logic        EX_VALID,
  input  logic [31:0] EX_PC,
  input  logic        EX_TAKEN,
  input  logic [31:0] EX_TARGET,
  input  logic        EX_PRED_TAKEN,
  input  logic [31:0] EX_PRED_TARGET,
  output logic        FLUSH,
  output logic [31:0] REDIRECT_PC,
  output logic [31:0] BR_COUNT,
  output logic [31:0] MISS_COUNT
);

  // EX_VALID qualifies every EX_* input for exactly one cycle; there is no
  // backpressure, so each valid cycle is consumed (trained) at the next edge.

  logic        valid_q  [ENTRIES];
  logic        valid_d  [ENTRIES];
  bp_tag_t     tag_q    [ENTRIES];
  bp_tag_t     tag_d    [ENTRIES];
  logic [31:0] target_q [ENTRIES];
  logic [31:0] target_d [ENTRIES];
  bp_ctr_e     ctr_q    [ENTRIES];
  bp_ctr_e     ctr_d    [ENTRIES];
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  bp_idx_t if_idx, ex_idx;
  bp_tag_t ex_tag;
  logic    if_hit, ex_hit;
  ctr_op_e ctr_op;
  bp_ctr_e ctr_next;

  assign if_idx = bp_index(IF_PC);
  assign ex_idx = bp_index(EX_PC);
  assign ex_tag = bp_tag(EX_PC);
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == bp_tag(IF_PC));
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Lookup reads the registered table, so a same-index update this cycle is not visible yet.
  assign PRED_TAKEN  = if_hit && ctr_q[if_idx][1];
  assign PRED_TARGET = PRED_TAKEN ? target_q[if_idx] : IF_PC + 32'd4;

  assign FLUSH = EX_VALID && ((EX_TAKEN != EX_PRED_TAKEN) ||
                              (EX_TAKEN && (EX_TARGET != EX_PRED_TARGET)));
  assign REDIRECT_PC = !FLUSH ? 32'd0 : (EX_TAKEN ? EX_TARGET : EX_PC + 32'd4);

  always_comb begin
    ctr_op = CTR_HOLD;
    if (EX_VALID) begin
      if (EX_TAKEN) ctr_op = ex_hit ? CTR_INC : CTR_INIT;
      else          ctr_op = ex_hit ? CTR_DEC : CTR_HOLD;
    end
  end

  bp_sat_counter u_ctr (
    .ctr_i (ctr_q[ex_idx]),
    .op_i  (ctr_op),
    .ctr_o (ctr_next)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (EX_VALID) begin
      // A taken resolve either refreshes a hit or claims the slot outright.
      if (EX_TAKEN) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = EX_TARGET;
      end
      ctr_d[ex_idx] = ctr_next;
    end
    br_count_d   = (EX_VALID && (br_count_q != '1)) ? br_count_q + 32'd1 : br_count_q;
    miss_count_d = (FLUSH && (miss_count_q != '1)) ? miss_count_q + 32'd1 : miss_count_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BP_SNT;
      end
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      ctr_q        <= ctr_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign BR_COUNT   = br_count_q;
  assign MISS_COUNT = miss_count_q;

endmodule
